// File: rtl/alu_traffic_gen.sv
// alu_traffic_gen: LFSR-driven ALU request generator with an in-order result scoreboard and watchdog.
module alu_traffic_gen #(
    parameter int          WIDTH   = 32,
    parameter int          TESTS   = 32,
    parameter int          DEPTH   = 4,
    parameter logic [31:0] SEED    = 32'h1,
    parameter logic [2:0]  OP_MASK = 3'b111,
    parameter int          TIMEOUT = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_alu_ready,
    output logic             o_alu_valid,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    output logic [1:0]       o_alu_op,
    input  logic             i_alu_res_valid,
    input  logic [WIDTH-1:0] i_alu_result,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic             o_timeout,
    output logic [15:0]      o_err_count
);
    localparam int          PW       = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int          CW       = $clog2(DEPTH + 1);
    localparam logic [31:0] POLY     = 32'h80200003;
    localparam logic [1:0]  FIRST_OP = OP_MASK[0] ? 2'd1 : OP_MASK[1] ? 2'd2 : 2'd3;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_d;

    logic [31:0]      lfsr_a, lfsr_b, wd;
    logic [1:0]       op;
    logic [15:0]      issued, err, err_d;
    logic [CW-1:0]    count, count_d;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [WIDTH-1:0] sb [DEPTH];
    logic [WIDTH-1:0] a, b, expected;
    logic             active, valid, xfer, res, pop, spurious, mismatch, wd_fire, start;

    function automatic logic [31:0] step(input logic [31:0] x);
        return x[0] ? (x >> 1) ^ POLY : x >> 1;
    endfunction

    function automatic logic [1:0] rot(input logic [1:0] x);
        return x == 2'd3 ? 2'd1 : x + 2'd1;
    endfunction

    // next enabled op after cur; cur itself when it is the only one enabled
    function automatic logic [1:0] next_op(input logic [1:0] cur);
        logic [1:0] n1, n2;
        n1 = rot(cur);
        n2 = rot(n1);
        return OP_MASK[n1 - 2'd1] ? n1 : OP_MASK[n2 - 2'd1] ? n2 : cur;
    endfunction

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    assign active   = state == RUN || state == DRAIN;
    assign valid    = state == RUN && issued < 16'(TESTS) && count < CW'(DEPTH);
    assign xfer     = valid && i_alu_ready;
    assign res      = i_alu_res_valid && active;
    assign pop      = res && count != '0;
    assign spurious = (res && count == '0) || (i_alu_res_valid && state == DONE);
    assign mismatch = pop && sb[rd_ptr] != i_alu_result;
    assign wd_fire  = active && count != '0 && !i_alu_res_valid && wd == 32'(TIMEOUT - 1);
    assign start    = i_start && (state == IDLE || state == DONE);
    assign count_d  = count + CW'(xfer) - CW'(pop);
    assign err_d    = start ? '0 : (mismatch || spurious || wd_fire) && err != 16'hFFFF ? err + 16'd1 : err;

    assign a           = lfsr_a[WIDTH-1:0];
    assign b           = lfsr_b[WIDTH-1:0];
    assign expected    = op == 2'd1 ? a + b : op == 2'd2 ? a - b : a ^ b;
    assign o_alu_valid = valid;
    assign o_alu_a     = valid ? a : '0;
    assign o_alu_b     = valid ? b : '0;
    assign o_alu_op    = valid ? op : 2'd0;
    assign o_err_count = err;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = i_start ? RUN : IDLE;
            RUN:     state_d = wd_fire ? DONE : issued + 16'(xfer) == 16'(TESTS) ? DRAIN : RUN;
            DRAIN:   state_d = wd_fire || count_d == '0 ? DONE : DRAIN;
            default: state_d = i_start ? RUN : DONE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            lfsr_a    <= SEED;
            lfsr_b    <= ~SEED;
            op        <= FIRST_OP;
            issued    <= '0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wd        <= '0;
            err       <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_pass    <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            state  <= state_d;
            err    <= err_d;
            o_busy <= state_d == RUN || state_d == DRAIN;
            o_done <= state_d == DONE;
            o_pass <= state_d == DONE && err_d == '0;
            if (start) begin
                lfsr_a    <= SEED;
                lfsr_b    <= ~SEED;
                op        <= FIRST_OP;
                issued    <= '0;
                count     <= '0;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                wd        <= '0;
                o_timeout <= 1'b0;
            end else begin
                if (xfer) begin
                    lfsr_a <= step(lfsr_a);
                    lfsr_b <= step(lfsr_b);
                    op     <= next_op(op);
                    issued <= issued + 16'd1;
                    wr_ptr <= inc(wr_ptr);
                end
                if (pop)
                    rd_ptr <= inc(rd_ptr);
                count <= count_d;
                wd    <= !active || count == '0 || i_alu_res_valid ? '0 : wd + 32'd1;
                // watchdog expiry abandons every outstanding result
                if (wd_fire) begin
                    count     <= '0;
                    wr_ptr    <= '0;
                    rd_ptr    <= '0;
                    wd        <= '0;
                    o_timeout <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (xfer)
            sb[wr_ptr] <= expected;
    end
endmodule

// File: tb/tb_alu_traffic_gen.sv
// tb_alu_traffic_gen: randomized ALU responder checked against a reference request/result model.
module tb_alu_traffic_gen;
    localparam int W = 32, N = 32, D = 4, TO = 100, N8 = 16;

    logic clk = 1'b0, rst_n = 1'b0;
    logic start = 1'b0, ready = 1'b0, res_valid = 1'b0;
    logic [W-1:0] result = '0;
    logic valid, busy, done, pass, tmo;
    logic [W-1:0] a, b;
    logic [1:0] op;
    logic [15:0] errc;

    logic start8 = 1'b0, ready8 = 1'b0, rv8 = 1'b0;
    logic [7:0] res8 = '0;
    logic valid8, busy8, done8, pass8, tmo8;
    logic [7:0] a8, b8;
    logic [1:0] op8;
    logic [15:0] err8;

    int checks = 0, fails = 0;
    logic [31:0] ma [N], mb [N];
    logic [1:0]  mo [N];

    always #5 clk = ~clk;

    alu_traffic_gen #(.WIDTH(W), .TESTS(N), .DEPTH(D), .SEED(32'h1), .OP_MASK(3'b111), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_alu_ready(ready),
        .o_alu_valid(valid), .o_alu_a(a), .o_alu_b(b), .o_alu_op(op),
        .i_alu_res_valid(res_valid), .i_alu_result(result),
        .o_busy(busy), .o_done(done), .o_pass(pass), .o_timeout(tmo), .o_err_count(errc));

    alu_traffic_gen #(.WIDTH(8), .TESTS(N8), .DEPTH(2), .SEED(32'h1), .OP_MASK(3'b100), .TIMEOUT(TO)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_alu_ready(ready8),
        .o_alu_valid(valid8), .o_alu_a(a8), .o_alu_b(b8), .o_alu_op(op8),
        .i_alu_res_valid(rv8), .i_alu_result(res8),
        .o_busy(busy8), .o_done(done8), .o_pass(pass8), .o_timeout(tmo8), .o_err_count(err8));

    function automatic logic [31:0] lfsr(input logic [31:0] x);
        return x[0] ? (x >> 1) ^ 32'h80200003 : x >> 1;
    endfunction

    function automatic logic [31:0] alu(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        return o == 2'd1 ? x + y : o == 2'd2 ? x - y : x ^ y;
    endfunction

    // request k of a run: k-th LFSR states, ops cycling ADD,SUB,XOR
    task automatic build_model;
        logic [31:0] x, y;
        x = 32'h1;
        y = ~32'h1;
        for (int k = 0; k < N; k++) begin
            ma[k] = x;
            mb[k] = y;
            mo[k] = 2'(k % 3 + 1);
            x = lfsr(x);
            y = lfsr(y);
        end
    endtask

    task automatic start_run;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({busy, done, pass, tmo, errc} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0}) begin
            fails++;
            $display("FAIL start_clear: got busy/done/pass/tmo/err=%b/%b/%b/%b/%0d want 1/0/0/0/0", busy, done, pass, tmo, errc);
        end
    endtask

    // mode: 0 ready always, 1 ready toggles, 2 ready random (with i_start noise)
    task automatic run(input int mode, input int lat_max, input int corrupt, input bit silent,
                       input int budget, output int xfers, output int cycles);
        logic [31:0] pq [$];
        int due [$];
        logic [W-1:0] pa, pb, r;
        logic [1:0] po;
        bit stalled;
        stalled = 0;
        xfers = 0;
        cycles = 0;
        pa = '0; pb = '0; po = '0;
        while (!done && cycles < budget) begin
            ready = mode == 0 ? 1'b1 : mode == 1 ? 1'(cycles % 2) : 1'($urandom_range(0, 1));
            start = mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
            res_valid = 1'b0;
            result = '0;
            if (pq.size() > 0 && due[0] <= cycles) begin
                res_valid = 1'b1;
                result = pq.pop_front();
                void'(due.pop_front());
            end
            if (stalled) begin
                checks++;
                if (!valid || {a, b, op} !== {pa, pb, po}) begin
                    fails++;
                    $display("FAIL stall_stable: got v=%b a=%h b=%h op=%0d want v=1 a=%h b=%h op=%0d", valid, a, b, op, pa, pb, po);
                end
            end
            if (valid && ready) begin
                checks++;
                if (xfers >= N) begin
                    fails++;
                    $display("FAIL extra_xfer: got transfer %0d want at most %0d", xfers + 1, N);
                end else begin
                    if ({a, b, op} !== {ma[xfers], mb[xfers], mo[xfers]}) begin
                        fails++;
                        $display("FAIL request[%0d]: got a=%h b=%h op=%0d want a=%h b=%h op=%0d",
                                 xfers, a, b, op, ma[xfers], mb[xfers], mo[xfers]);
                    end
                    r = alu(mo[xfers], ma[xfers], mb[xfers]);
                    if (xfers == corrupt)
                        r[0] = ~r[0];
                    if (!silent) begin
                        pq.push_back(r);
                        due.push_back(cycles + int'($urandom_range(1, lat_max)));
                    end
                end
                xfers++;
            end
            stalled = valid && !ready;
            pa = a; pb = b; po = op;
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;
        ready = 1'b0;
        res_valid = 1'b0;
    endtask

    task automatic check_end(input string name, input int xfers, input bit exp_pass, input logic [15:0] exp_err);
        checks++;
        if (xfers != N || done !== 1'b1 || busy !== 1'b0 || pass !== exp_pass || errc !== exp_err) begin
            fails++;
            $display("FAIL %s_end: got xfers=%0d done=%b busy=%b pass=%b err=%0d want %0d/1/0/%b/%0d",
                     name, xfers, done, busy, pass, errc, N, exp_pass, exp_err);
        end
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({valid, busy, done, pass, tmo, errc, op, a, b} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b busy=%b done=%b pass=%b tmo=%b err=%0d op=%0d a=%h b=%h want all 0",
                     valid, busy, done, pass, tmo, errc, op, a, b);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL no_start_idle: got valid=%b busy=%b want 0/0", valid, busy);
        end
        ready = 1'b0;
    endtask

    task automatic test_basic;
        int x, c;
        start_run();
        checks++;
        if ({valid, a, b, op} !== {1'b1, 32'h1, 32'hFFFFFFFE, 2'd1}) begin
            fails++;
            $display("FAIL first_request: got v=%b a=%h b=%h op=%0d want 1 00000001 fffffffe 1", valid, a, b, op);
        end
        run(0, 1, -1, 0, 2000, x, c);
        check_end("basic", x, 1'b1, 16'd0);
    endtask

    task automatic test_corrupt;
        int x, c;
        start_run();
        run(0, 3, 2, 0, 2000, x, c);
        check_end("corrupt", x, 1'b0, 16'd1);
    endtask

    task automatic test_back_to_back;
        int x, c;
        start_run();
        run(1, 6, -1, 0, 2000, x, c);
        check_end("toggle", x, 1'b1, 16'd0);
        start_run();
        run(2, 7, -1, 0, 2000, x, c);
        check_end("random", x, 1'b1, 16'd0);
    endtask

    task automatic test_timeout;
        int x, c;
        start_run();
        run(0, 1, -1, 1, TO + 50, x, c);
        checks++;
        if (x != D || c < TO || c > TO + 2) begin
            fails++;
            $display("FAIL timeout_timing: got xfers=%0d cycles=%0d want %0d and %0d..%0d", x, c, D, TO, TO + 2);
        end
        checks++;
        if ({done, tmo, pass, errc} !== {1'b1, 1'b1, 1'b0, 16'd1}) begin
            fails++;
            $display("FAIL timeout_flags: got done/tmo/pass/err=%b/%b/%b/%0d want 1/1/0/1", done, tmo, pass, errc);
        end
        res_valid = 1'b1;
        @(posedge clk); #1;
        res_valid = 1'b0;
        checks++;
        if (errc !== 16'd2 || pass !== 1'b0 || done !== 1'b1) begin
            fails++;
            $display("FAIL spurious_done: got err=%0d pass=%b done=%b want 2/0/1", errc, pass, done);
        end
    endtask

    task automatic test_mid_reset;
        int x, c;
        start_run();
        ready = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({valid, busy, done, pass, tmo, errc, op, a} !== '0) begin
            fails++;
            $display("FAIL async_reset: got v=%b busy=%b done=%b pass=%b tmo=%b err=%0d op=%0d a=%h want all 0",
                     valid, busy, done, pass, tmo, errc, op, a);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        res_valid = 1'b1;
        @(posedge clk); #1;
        res_valid = 1'b0;
        ready = 1'b0;
        checks++;
        if (errc !== 16'd0 || done !== 1'b0 || valid !== 1'b0) begin
            fails++;
            $display("FAIL idle_result_ignored: got err=%0d done=%b valid=%b want 0/0/0", errc, done, valid);
        end
        start_run();
        checks++;
        if ({valid, a, b, op} !== {1'b1, 32'h1, 32'hFFFFFFFE, 2'd1}) begin
            fails++;
            $display("FAIL restart_request: got v=%b a=%h b=%h op=%0d want 1 00000001 fffffffe 1", valid, a, b, op);
        end
        run(2, 4, -1, 0, 2000, x, c);
        check_end("restart", x, 1'b1, 16'd0);
    endtask

    task automatic test_xor_w8;
        int k, cyc;
        bit pend;
        logic [7:0] pr;
        k = 0; cyc = 0; pend = 0; pr = '0;
        ready8 = 1'b1;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        while (!done8 && cyc < 500) begin
            rv8 = pend;
            res8 = pr;
            pend = 0;
            if (valid8) begin
                checks++;
                if (k >= N8 || {a8, b8, op8} !== {ma[k][7:0], mb[k][7:0], 2'd3}) begin
                    fails++;
                    $display("FAIL w8_request[%0d]: got a=%h b=%h op=%0d want a=%h b=%h op=3",
                             k, a8, b8, op8, ma[k % N][7:0], mb[k % N][7:0]);
                end
                pr = ma[k % N][7:0] ^ mb[k % N][7:0];
                pend = 1;
                k++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        rv8 = 1'b0;
        ready8 = 1'b0;
        checks++;
        if (k != N8 || {done8, pass8, tmo8, busy8, err8} !== {1'b1, 1'b1, 1'b0, 1'b0, 16'd0}) begin
            fails++;
            $display("FAIL w8_end: got xfers=%0d done/pass/tmo/busy/err=%b/%b/%b/%b/%0d want %0d 1/1/0/0/0",
                     k, done8, pass8, tmo8, busy8, err8, N8);
        end
    endtask

    initial begin
        build_model();
        test_reset();
        test_basic();
        test_corrupt();
        test_back_to_back();
        test_timeout();
        test_mid_reset();
        test_xor_w8();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach its summary");
        $fatal(1, "tb_alu_traffic_gen stuck");
    end
endmodule
